uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_rx_ovs.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 2-of-3 majority voting, single-entry holding
// register with valid/ready handoff, sticky overrun flag and optional line-break
// detection. Define UART_RX_BREAK_DET_EN to enable break_det; otherwise break_det
// is tied to 0 and a break is delivered as a 0x00 frame with framing_error set.
module uart_rx_ovs #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned OVS       = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  input  logic       rx_ready,
  input  logic       overrun_clr,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       parity_error,
  output logic       framing_error,
  output logic       start_pulse,
  output logic       overrun,
  output logic       break_det
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVS);
  localparam int unsigned DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW       = $clog2(OVS);

  localparam logic [DW-1:0] DivLast  = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SmpLast  = SW'(OVS - 1);
  localparam logic [SW-1:0] Smp0     = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] Smp1     = SW'(OVS / 2);
  localparam logic [SW-1:0] Smp2     = SW'(OVS / 2 + 1);
  localparam logic [3:0]    DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StHoldoff} state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DW-1:0]          div_q, div_d;
  logic [SW-1:0]          smp_cnt_q, smp_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   fperr_q, fperr_d, fferr_q, fferr_d, zero_q, zero_d;
  logic                   rx_valid_d, parity_error_d, framing_error_d;
  logic                   start_pulse_d, overrun_d, break_det_d;
  logic [7:0]             rx_byte_d;
  logic                   tick, fall, decide, maj, complete, ferr_n, exp_par, accept;

  // Two-flop synchronizer plus delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // State, counters, frame datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      div_q         <= '0;
      smp_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      smp_q         <= '0;
      shreg_q       <= '0;
      fperr_q       <= 1'b0;
      fferr_q       <= 1'b0;
      zero_q        <= 1'b0;
      rx_valid      <= 1'b0;
      rx_byte       <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      start_pulse   <= 1'b0;
      overrun       <= 1'b0;
      break_det     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      smp_cnt_q     <= smp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      smp_q         <= smp_d;
      shreg_q       <= shreg_d;
      fperr_q       <= fperr_d;
      fferr_q       <= fferr_d;
      zero_q        <= zero_d;
      rx_valid      <= rx_valid_d;
      rx_byte       <= rx_byte_d;
      parity_error  <= parity_error_d;
      framing_error <= framing_error_d;
      start_pulse   <= start_pulse_d;
      overrun       <= overrun_d;
      break_det     <= break_det_d;
    end
  end

  // Next-state, bit sampling, frame assembly and holding-register handoff.
  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    smp_d       = smp_q;
    shreg_d     = shreg_q;
    fperr_d     = fperr_q;
    fferr_d     = fferr_q;
    zero_d      = zero_q;
    start_pulse_d = 1'b0;
    break_det_d = 1'b0;
    complete    = 1'b0;
    ferr_n      = fferr_q;
    exp_par     = (PARITY == 1) ? ~^shreg_q : ^shreg_q;

    tick   = (div_q == DivLast);
    fall   = rx_prev_q & ~rx_sync_q;
    div_d  = tick ? '0 : div_q + DW'(1);
    decide = tick && (smp_cnt_q == Smp2);
    maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);

    // Sample counter keeps running across bit boundaries; every bit decides at Smp2.
    if (state_q inside {StStart, StData, StParity, StStop} && tick) begin
      smp_cnt_d = (smp_cnt_q == SmpLast) ? '0 : smp_cnt_q + SW'(1);
      if (smp_cnt_q == Smp0) smp_d[0] = rx_sync_q;
      if (smp_cnt_q == Smp1) smp_d[1] = rx_sync_q;
    end

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d   = StStart;
          div_d     = '0;
          smp_cnt_d = '0;
          bit_cnt_d = '0;
          fperr_d   = 1'b0;
          fferr_d   = 1'b0;
          zero_d    = 1'b1;
        end
      end
      StStart: begin
        if (decide) begin
          if (maj) begin
            state_d = StIdle;
          end else begin
            start_pulse_d = 1'b1;
            state_d       = StData;
          end
        end
      end
      StData: begin
        if (decide) begin
          shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~maj;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (decide) begin
          fperr_d = (maj != exp_par);
          zero_d  = zero_q & ~maj;
          state_d = StStop;
        end
      end
      StStop: begin
        if (decide) begin
          ferr_n  = fferr_q | ~maj;
          fferr_d = ferr_n;
`ifdef UART_RX_BREAK_DET_EN
          if (bit_cnt_q == 4'd0 && zero_q && !maj) begin
            break_det_d = 1'b1;
            state_d     = StHoldoff;
          end else
`endif
          if (bit_cnt_q == StopLast) begin
            complete = 1'b1;
            state_d  = StHoldoff;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StHoldoff: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Holding register: a completing frame loads only if the slot is free or being
    // drained this cycle; otherwise it is dropped and flagged as an overrun.
    accept          = rx_valid & rx_ready;
    rx_valid_d      = rx_valid;
    rx_byte_d       = rx_byte;
    parity_error_d  = parity_error;
    framing_error_d = framing_error;
    overrun_d       = overrun;
    if (complete && (!rx_valid || accept)) begin
      rx_valid_d      = 1'b1;
      rx_byte_d       = 8'(shreg_q);
      parity_error_d  = fperr_q;
      framing_error_d = ferr_n;
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end
    if (complete && rx_valid && !rx_ready) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: one 8N1 instance and one 7E2 instance.
module tb_uart_rx_ovs;

  localparam int BIT = 432; // clocks per bit: 27-clock tick times 16 samples

  typedef struct packed {
    logic [7:0] b;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_a = 1'b1, rdy_a = 1'b1, oclr_a = 1'b0;
  logic       rx_b = 1'b1, rdy_b = 1'b1, oclr_b = 1'b0;
  logic       val_a, pe_a, fe_a, sp_a, ov_a, bk_a;
  logic       val_b, pe_b, fe_b, sp_b, ov_b, bk_b;
  logic [7:0] byte_a, byte_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0, errors = 0;
  int   starts_a = 0, starts_b = 0, breaks_a = 0, exp_brk_a = 0;
  bit   acc_prev_a = 0, acc_prev_b = 0;

  always #5 clk = ~clk;

  uart_rx_ovs dut_a (
    .clk(clk), .rstn(rstn), .rx(rx_a), .rx_ready(rdy_a), .overrun_clr(oclr_a),
    .rx_valid(val_a), .rx_byte(byte_a), .parity_error(pe_a), .framing_error(fe_a),
    .start_pulse(sp_a), .overrun(ov_a), .break_det(bk_a)
  );

  uart_rx_ovs #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rstn(rstn), .rx(rx_b), .rx_ready(rdy_b), .overrun_clr(oclr_b),
    .rx_valid(val_b), .rx_byte(byte_b), .parity_error(pe_b), .framing_error(fe_b),
    .start_pulse(sp_b), .overrun(ov_b), .break_det(bk_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame bits and the expected delivered result.
  task automatic build(input logic [7:0] data, input int dbits, input int pmode,
                       input bit pflip, input bit s1, input bit s2, input int nstop,
                       output logic [15:0] bits, output int n, output exp_t e,
                       output bit brk);
    logic [7:0] d;
    int         ones;
    bit         pbit;
    d    = data & 8'((1 << dbits) - 1);
    ones = $countones(d);
    pbit = ((pmode == 1) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ pflip;
    bits = '0;
    n    = 1; // start bit 0
    for (int i = 0; i < dbits; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (pmode != 0) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = s1;
    n++;
    if (nstop == 2) begin
      bits[n] = s2;
      n++;
    end
    e.b  = d;
    e.pe = (pmode != 0) && (((ones + int'(pbit)) % 2) != ((pmode == 1) ? 1 : 0));
    e.fe = !s1 || (nstop == 2 && !s2);
    brk  = (d == 0) && (pmode == 0 || !pbit) && !s1;
  endtask

  task automatic send(input bit which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) rx_b = bits[i];
      else       rx_a = bits[i];
      repeat (BIT) @(posedge clk);
    end
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic frame_a(input logic [7:0] data, input bit s1, input bit push);
    logic [15:0] bits;
    int          n;
    exp_t        e;
    bit          brk;
    build(data, 8, 0, 1'b0, s1, 1'b1, 1, bits, n, e, brk);
    if (push) begin
`ifdef UART_RX_BREAK_DET_EN
      if (brk) exp_brk_a++;
      else     q_a.push_back(e);
`else
      q_a.push_back(e);
`endif
    end
    send(1'b0, bits, n);
  endtask

  task automatic frame_b(input logic [7:0] data, input bit pflip, input bit s2);
    logic [15:0] bits;
    int          n;
    exp_t        e;
    bit          brk;
    build(data, 7, 2, pflip, 1'b1, s2, 2, bits, n, e, brk);
    q_b.push_back(e);
    send(1'b1, bits, n);
  endtask

  // Pulse counters.
  always @(negedge clk) begin
    if (sp_a) starts_a++;
    if (sp_b) starts_b++;
    if (bk_a) breaks_a++;
  end

  // Monitor for instance A: compare on every handshake; valid must drop right after.
  always @(negedge clk) begin
    if (acc_prev_a) chk("a_valid_one_clk", val_a, 0);
    acc_prev_a = 0;
    if (rstn && val_a && rdy_a) begin
      acc_prev_a = 1;
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got byte %0h expected no output", byte_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_byte", byte_a, e.b);
        chk("a_parity_error", pe_a, e.pe);
        chk("a_framing_error", fe_a, e.fe);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (acc_prev_b) chk("b_valid_one_clk", val_b, 0);
    acc_prev_b = 0;
    if (rstn && val_b && rdy_b) begin
      acc_prev_b = 1;
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got byte %0h expected no output", byte_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_byte", byte_b, e.b);
        chk("b_parity_error", pe_b, e.pe);
        chk("b_framing_error", fe_b, e.fe);
      end
    end
  end

  initial begin
    int          s0;
    logic [15:0] bits;
    int          n;
    exp_t        e;
    bit          brk;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", val_a, 0);
    chk("rst_byte", byte_a, 0);
    chk("rst_pe", pe_a, 0);
    chk("rst_fe", fe_a, 0);
    chk("rst_start", sp_a, 0);
    chk("rst_overrun", ov_a, 0);
    chk("rst_break", bk_a, 0);
    @(posedge clk);
    rstn = 1'b1;
    repeat (20) @(posedge clk);

    frame_a(8'hA5, 1'b1, 1'b1);

    // Short low pulse must be rejected as a false start.
    s0   = starts_a;
    rx_a = 1'b0;
    repeat (100) @(posedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    chk("glitch_no_start", starts_a, s0);

    for (int i = 0; i < 6; i++) begin
      frame_a(8'($urandom_range(1, 255)), $urandom_range(0, 3) != 0, 1'b1);
    end
    chk("no_overrun_when_ready", ov_a, 0);

    // Overrun: second frame is dropped while the first is held.
    rdy_a = 1'b0;
    frame_a(8'h11, 1'b1, 1'b1);
    frame_a(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    chk("ovr_flag_set", ov_a, 1);
    chk("ovr_held_byte", byte_a, 8'h11);
    chk("ovr_valid_held", val_a, 1);
    @(posedge clk);
    oclr_a = 1'b1;
    @(posedge clk);
    oclr_a = 1'b0;
    @(negedge clk);
    chk("ovr_flag_cleared", ov_a, 0);
    rdy_a = 1'b1;
    repeat (10) @(posedge clk);

    // Line break: 12 bit times low.
`ifdef UART_RX_BREAK_DET_EN
    exp_brk_a++;
`else
    e.b  = 8'h00;
    e.pe = 1'b0;
    e.fe = 1'b1;
    q_a.push_back(e);
`endif
    rx_a = 1'b0;
    repeat (12 * BIT) @(posedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT) @(posedge clk);

    frame_b(8'h3C, 1'b1, 1'b1);
    frame_b(8'h7F, 1'b0, 1'b0);

    // Repeat send with reset asserted mid-frame and held to the end of the frame.
    build(8'h7F, 7, 2, 1'b0, 1'b1, 1'b0, 2, bits, n, e, brk);
    for (int i = 0; i < n; i++) begin
      if (i == 5) rstn = 1'b0;
      rx_b = bits[i];
      repeat (BIT) @(posedge clk);
    end
    rx_b = 1'b1;
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("b_rst_byte", byte_b, 0);
    chk("b_rst_fe", fe_b, 0);
    @(posedge clk);
    rstn = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    @(negedge clk);
    chk("b_no_valid_after_abort", val_b, 0);

    chk("a_start_count", starts_a, 10);
    chk("b_start_count", starts_b, 3);
    chk("a_break_count", breaks_a, exp_brk_a);
    chk("a_scoreboard_drained", q_a.size(), 0);
    chk("b_scoreboard_drained", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
